// File: rtl/descriptions.sv
// ---------------------------------------------------------------------------
// descriptions: shared types and constants for the odd-pipe result stage.
//   odd_packet_t : 143-bit odd-pipe output packet (result in the low bits).
//   stage_t      : one staging-pipe entry as held by odd_result_stage.
//   is_live()    : true when a packet should enter the staging pipe.
// ---------------------------------------------------------------------------
package descriptions;

  localparam int ODD_PKT_W  = 143;
  localparam int ODD_STAGES = 7;
  localparam int RESULT_W   = 128;
  localparam int ADDR_W     = 7;

  // Field order is MSB first, so result occupies bits [127:0].
  typedef struct packed {
    logic [3:0]          unit_id;  // [142:139]
    logic [2:0]          latency;  // [138:136]
    logic                wen;      // [135]
    logic [ADDR_W-1:0]   rt;       // [134:128]
    logic [RESULT_W-1:0] result;   // [127:0]
  } odd_packet_t;

  // Only valid entries are write-enabled, and the unit id has already been
  // screened at entry, so neither is carried down the pipe.
  typedef struct packed {
    logic                valid;
    logic [2:0]          latency;
    logic [ADDR_W-1:0]   rt;
    logic [RESULT_W-1:0] result;
  } stage_t;

  // Latency 0 or unit id 0 marks an illegal packet that must be dropped.
  function automatic logic is_live(input odd_packet_t pkt);
    return pkt.wen && (pkt.latency != 3'd0) && (pkt.unit_id != 4'd0);
  endfunction

endpackage

// File: rtl/odd_fwd_lookup.sv
// ---------------------------------------------------------------------------
// odd_fwd_lookup: forwarding lookup for one operand address.
//   stages   in   staging entries, index 1 is the youngest
//   wb_valid/wb_rt/wb_data  in  registered writeback entry (oldest, ready)
//   address  in   operand register address
//   hit      out  youngest matching entry is ready
//   pending  out  youngest matching entry is not ready yet
//   data     out  forwarded result, 0 unless hit
// ---------------------------------------------------------------------------
module odd_fwd_lookup
  import descriptions::*;
#(
  parameter int DEPTH = ODD_STAGES
) (
  input  stage_t [DEPTH:1]      stages,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_rt,
  input  logic [RESULT_W-1:0]   wb_data,
  input  logic [ADDR_W-1:0]     address,
  output logic                  hit,
  output logic                  pending,
  output logic [RESULT_W-1:0]   data
);

  // Walk oldest to youngest so a younger match simply overwrites an older
  // one; the last writer is the youngest match, ready or not.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    hit     = 1'b0;
    pending = 1'b0;
    data    = '0;
    if (wb_valid && (wb_rt == address)) begin
      hit  = 1'b1;
      data = wb_data;
    end
    for (int s = DEPTH; s >= 1; s--) begin
      if (stages[s].valid && (stages[s].rt == address)) begin
        if (s >= int'(stages[s].latency)) begin
          hit     = 1'b1;
          pending = 1'b0;
          data    = stages[s].result;
        end else begin
          hit     = 1'b0;
          pending = 1'b1;
          data    = '0;
        end
      end
    end
  end

endmodule

// File: rtl/odd_result_stage.sv
// ---------------------------------------------------------------------------
// odd_result_stage: result staging / writeback pipe behind the odd pipe.
// Optional feature macro: ODD_RESULT_FWD_EN builds the forwarding lookup;
// without it the fwd_* outputs are tied to 0.
//   clock, reset (async, active low)
//   in_packet    odd-pipe output packet (see descriptions::odd_packet_t)
//   in_flush     drop this cycle's packet and the stage-1 entry
//   ra/rb/rc_address  forwarding lookup addresses
//   fwd_hit/fwd_pending  bit 0 = ra, bit 1 = rb, bit 2 = rc
//   fwd_ra/rb/rc forwarded data (0 when no hit)
//   wb_wrt_en/wb_rt_address/wb_data  registered writeback from stage DEPTH
// ---------------------------------------------------------------------------
module odd_result_stage
  import descriptions::*;
#(
  parameter int DEPTH = ODD_STAGES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ODD_PKT_W-1:0] in_packet,
  input  logic                 in_flush,
  input  logic [ADDR_W-1:0]    ra_address,
  input  logic [ADDR_W-1:0]    rb_address,
  input  logic [ADDR_W-1:0]    rc_address,
  output logic [2:0]           fwd_hit,
  output logic [2:0]           fwd_pending,
  output logic [RESULT_W-1:0]  fwd_ra,
  output logic [RESULT_W-1:0]  fwd_rb,
  output logic [RESULT_W-1:0]  fwd_rc,
  output logic                 wb_wrt_en,
  output logic [ADDR_W-1:0]    wb_rt_address,
  output logic [RESULT_W-1:0]  wb_data
);

  odd_packet_t      pkt;
  stage_t [DEPTH:1] stage_q;

  assign pkt = odd_packet_t'(in_packet);

  // NOTE: the staging array is a handful of flops rather than a RAM, so it is
  // reset in full; that keeps dead payload off wb_data after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q       <= '0;
      wb_wrt_en     <= 1'b0;
      wb_rt_address <= '0;
      wb_data       <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what turns this loop into a shift.
      for (int s = 2; s <= DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
      // A flushed stage-1 entry dies instead of moving on.
      if (in_flush) begin
        stage_q[2].valid <= 1'b0;
      end
      if (is_live(pkt) && !in_flush) begin
        stage_q[1] <= stage_t'({1'b1, pkt.latency, pkt.rt, pkt.result});
      end else begin
        stage_q[1] <= '0;
      end
      wb_wrt_en     <= stage_q[DEPTH].valid;
      wb_rt_address <= stage_q[DEPTH].rt;
      wb_data       <= stage_q[DEPTH].result;
    end
  end

`ifdef ODD_RESULT_FWD_EN
  odd_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_ra (
    .stages   (stage_q),
    .wb_valid (wb_wrt_en),
    .wb_rt    (wb_rt_address),
    .wb_data  (wb_data),
    .address  (ra_address),
    .hit      (fwd_hit[0]),
    .pending  (fwd_pending[0]),
    .data     (fwd_ra)
  );

  odd_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_rb (
    .stages   (stage_q),
    .wb_valid (wb_wrt_en),
    .wb_rt    (wb_rt_address),
    .wb_data  (wb_data),
    .address  (rb_address),
    .hit      (fwd_hit[1]),
    .pending  (fwd_pending[1]),
    .data     (fwd_rb)
  );

  odd_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_rc (
    .stages   (stage_q),
    .wb_valid (wb_wrt_en),
    .wb_rt    (wb_rt_address),
    .wb_data  (wb_data),
    .address  (rc_address),
    .hit      (fwd_hit[2]),
    .pending  (fwd_pending[2]),
    .data     (fwd_rc)
  );
`else
  assign fwd_hit     = '0;
  assign fwd_pending = '0;
  assign fwd_ra      = '0;
  assign fwd_rb      = '0;
  assign fwd_rc      = '0;

  // Lookup addresses and stage latencies have no reader in this build.
  logic unused_fwd;
  assign unused_fwd = ^{ra_address, rb_address, rc_address, stage_q};
`endif

endmodule

// File: tb/tb_odd_result_stage.sv
// ---------------------------------------------------------------------------
// tb_odd_result_stage: directed self-checking bench for odd_result_stage.
// Follows ODD_RESULT_FWD_EN: with it undefined all fwd_* are expected 0.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_odd_result_stage;

`ifdef ODD_RESULT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic [142:0] in_packet;
  logic         in_flush;
  logic [6:0]   ra_address, rb_address, rc_address;
  logic [2:0]   fwd_hit, fwd_pending;
  logic [127:0] fwd_ra, fwd_rb, fwd_rc;
  logic         wb_wrt_en;
  logic [6:0]   wb_rt_address;
  logic [127:0] wb_data;

  int checks = 0;
  int fails  = 0;

  odd_result_stage dut (
    .clock         (clock),
    .reset         (reset),
    .in_packet     (in_packet),
    .in_flush      (in_flush),
    .ra_address    (ra_address),
    .rb_address    (rb_address),
    .rc_address    (rc_address),
    .fwd_hit       (fwd_hit),
    .fwd_pending   (fwd_pending),
    .fwd_ra        (fwd_ra),
    .fwd_rb        (fwd_rb),
    .fwd_rc        (fwd_rc),
    .wb_wrt_en     (wb_wrt_en),
    .wb_rt_address (wb_rt_address),
    .wb_data       (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [142:0] mk(input logic [3:0] unit_id,
                                      input logic [2:0] latency,
                                      input logic wen,
                                      input logic [6:0] rt,
                                      input logic [127:0] result);
    return {unit_id, latency, wen, rt, result};
  endfunction

  task automatic check(input string name, input logic [127:0] observed,
                       input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic expect_fwd(input string name, input logic [2:0] hit,
                            input logic [2:0] pend, input logic [127:0] dra,
                            input logic [127:0] drb, input logic [127:0] drc);
    check({name, ".hit"},  fwd_hit,     FWD ? hit  : 3'b000);
    check({name, ".pend"}, fwd_pending, FWD ? pend : 3'b000);
    check({name, ".ra"},   fwd_ra,      FWD ? dra  : 128'h0);
    check({name, ".rb"},   fwd_rb,      FWD ? drb  : 128'h0);
    check({name, ".rc"},   fwd_rc,      FWD ? drc  : 128'h0);
  endtask

  task automatic expect_wb(input string name, input logic en,
                           input logic [6:0] rt, input logic [127:0] data);
    check({name, ".wb_en"},   wb_wrt_en,     en);
    check({name, ".wb_rt"},   wb_rt_address, rt);
    check({name, ".wb_data"}, wb_data,       data);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input logic [6:0] a, input logic [6:0] b,
                          input logic [6:0] c);
    ra_address = a;
    rb_address = b;
    rc_address = c;
  endtask

  initial begin
    reset     = 1'b0;
    in_packet = '0;
    in_flush  = 1'b0;
    set_addr(7'd0, 7'd0, 7'd0);

    // ---- reset state ----
    #12;
    expect_wb("rst", 1'b0, 7'd0, 128'h0);
    expect_fwd("rst", 3'b000, 3'b000, 0, 0, 0);
    reset = 1'b1;
    tick();

    // ---- single packet: rt=5, A5, latency 2 ----
    set_addr(7'd5, 7'd5, 7'd5);
    in_packet = mk(4'd1, 3'd2, 1'b1, 7'd5, 128'hA5);
    tick();                                   // accepted, now in stage 1
    in_packet = '0;
    expect_fwd("sp_s1", 3'b000, 3'b111, 0, 0, 0);
    expect_wb("sp_s1", 1'b0, 7'd0, 128'h0);
    tick();                                   // stage 2: ready
    expect_fwd("sp_s2", 3'b111, 3'b000, 128'hA5, 128'hA5, 128'hA5);
    rb_address = 7'd6;                        // operands resolve independently
    expect_fwd("sp_split", 3'b101, 3'b000, 128'hA5, 128'h0, 128'hA5);
    rb_address = 7'd5;
    for (int j = 3; j <= 7; j++) begin
      tick();
      expect_fwd("sp_stage", 3'b111, 3'b000, 128'hA5, 128'hA5, 128'hA5);
      check("sp_nowb", wb_wrt_en, 1'b0);
    end
    tick();                                   // edge N+7: writeback
    expect_wb("sp_wb", 1'b1, 7'd5, 128'hA5);
    expect_fwd("sp_wbfwd", 3'b111, 3'b000, 128'hA5, 128'hA5, 128'hA5);
    tick();
    expect_wb("sp_after", 1'b0, 7'd0, 128'h0);
    expect_fwd("sp_after", 3'b000, 3'b000, 0, 0, 0);

    // ---- same-rt hazard ----
    set_addr(7'd9, 7'd9, 7'd9);
    in_packet = mk(4'd2, 3'd4, 1'b1, 7'd9, 128'h1);
    tick();                                   // A in stage 1
    in_packet = mk(4'd3, 3'd7, 1'b1, 7'd9, 128'h2);
    expect_fwd("hz_a1", 3'b000, 3'b111, 0, 0, 0);
    tick();                                   // B in stage 1, A in stage 2
    in_packet = '0;
    expect_fwd("hz_b1", 3'b000, 3'b111, 0, 0, 0);
    for (int j = 2; j <= 6; j++) begin
      tick();                                 // A ready from j=3, B is younger
      expect_fwd("hz_pend", 3'b000, 3'b111, 0, 0, 0);
      check("hz_nowb", wb_wrt_en, 1'b0);
    end
    tick();                                   // A written back, B stage 7
    expect_wb("hz_wb1", 1'b1, 7'd9, 128'h1);
    expect_fwd("hz_b7", 3'b111, 3'b000, 128'h2, 128'h2, 128'h2);
    tick();
    expect_wb("hz_wb2", 1'b1, 7'd9, 128'h2);
    expect_fwd("hz_bwb", 3'b111, 3'b000, 128'h2, 128'h2, 128'h2);
    tick();
    expect_wb("hz_done", 1'b0, 7'd0, 128'h0);

    // ---- flush ----
    set_addr(7'd3, 7'd4, 7'd3);
    in_packet = mk(4'd1, 3'd1, 1'b1, 7'd3, 128'h33);
    tick();                                   // A in stage 1
    in_packet = mk(4'd1, 3'd1, 1'b1, 7'd4, 128'h44);
    in_flush  = 1'b1;
    expect_fwd("fl_pre", 3'b101, 3'b000, 128'h33, 128'h0, 128'h33);
    tick();
    in_flush  = 1'b0;
    in_packet = '0;
    for (int j = 0; j < 9; j++) begin
      expect_fwd("fl_gone", 3'b000, 3'b000, 0, 0, 0);
      check("fl_nowb", wb_wrt_en, 1'b0);
      tick();
    end

    // ---- illegal / disabled packets for rt=12 ----
    set_addr(7'd12, 7'd12, 7'd12);
    in_packet = mk(4'd1, 3'd3, 1'b0, 7'd12, 128'hC0);  // wen=0
    tick();
    in_packet = mk(4'd1, 3'd0, 1'b1, 7'd12, 128'hC1);  // latency 0
    tick();
    in_packet = mk(4'd0, 3'd3, 1'b1, 7'd12, 128'hC2);  // unit id 0
    tick();
    in_packet = '0;
    for (int j = 0; j < 9; j++) begin
      expect_fwd("il_none", 3'b000, 3'b000, 0, 0, 0);
      check("il_nowb", wb_wrt_en, 1'b0);
      tick();
    end

    // ---- reset mid-stream ----
    set_addr(7'd21, 7'd21, 7'd21);
    for (int i = 0; i < 7; i++) begin
      in_packet = mk(4'd1, 3'd1, 1'b1, 7'(20 + i), 128'(100 + i));
      tick();
    end
    in_packet = '0;
    expect_fwd("rs_full", 3'b111, 3'b000, 128'd101, 128'd101, 128'd101);
    check("rs_nowb", wb_wrt_en, 1'b0);
    tick();
    expect_wb("rs_wb", 1'b1, 7'd20, 128'd100);
    #3;
    reset = 1'b0;
    #1;
    expect_wb("rs_async", 1'b0, 7'd0, 128'h0);
    expect_fwd("rs_async", 3'b000, 3'b000, 0, 0, 0);
    #2;
    reset = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick();
      check("rs_nowb_after", wb_wrt_en, 1'b0);
      expect_fwd("rs_none", 3'b000, 3'b000, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/odd_result_stage.md
# odd_result_stage

Result staging and writeback pipe directly downstream of the odd pipe (`oddpipe`). It captures each 143-bit odd-pipe output packet and holds it in a 7-deep shift pipeline. It retires the packet to the register file at a fixed depth and exposes a forwarding lookup for the ra/rb/rc operands of the next issue. Operands that are in flight but not yet ready are flagged so the issue stage can stall.

## Interface
Parameters:
- DEPTH, 7, number of staging stages; writeback leaves stage DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_packet  in  143  odd-pipe output, laid out as:
  - [0:127] result
  - [128:134] rt address
  - [135] write enable
  - [136:138] latency (1–7)
  - [139:142] unit id
- in_flush  in  1  kill the packet presented this cycle and the stage-1 entry.
- ra_address, rb_address, rc_address  in  7 each  forwarding lookup addresses.
- fwd_hit  out  3  per operand (ra, rb, rc): a ready matching entry exists.
- fwd_pending  out  3  per operand: the youngest matching entry is not yet ready.
- fwd_ra, fwd_rb, fwd_rc  out  128 each  forwarded data; 0 when there is no hit.
- wb_wrt_en  out  1  register-file write strobe.
- wb_rt_address  out  7  writeback target.
- wb_data  out  128  writeback value.

## Operation
- Each stage s (1..DEPTH) holds: valid, result, rt, wen, latency, unit id.
- A packet counts as live only when wen=1 and latency is nonzero. A live packet enters stage 1 each cycle; otherwise stage 1 loads valid=0.
- Every cycle, stage s+1 loads stage s. There are no bubbles and no backpressure; the pipe always advances.
- An entry in stage s is ready when s ≥ latency.
- Writeback: on every clock, the registered outputs take the following values from stage DEPTH.
  - wb_wrt_en takes stage DEPTH's valid.
  - wb_rt_address takes stage DEPTH's rt.
  - wb_data takes stage DEPTH's result.
- Forwarding (combinational), per operand:
  - Scan stages 1..DEPTH and the registered wb output, youngest first (stage 1 first, wb output last).
  - The first valid entry whose rt equals the address decides the result.
  - If that entry is ready (the wb output is always ready): hit=1, pending=0, data=result.
  - If it is not ready: hit=0, pending=1, data=0.
  - If nothing matches: hit=0, pending=0, data=0.
  - An older ready match never overrides a younger non-ready one.
- in_flush:
  - The in_packet presented this cycle is discarded.
  - Stage 1 is cleared at the next edge, i.e. the entry currently in stage 1 is invalidated instead of advancing to stage 2.
  - Stages 2..DEPTH advance normally.
- Simultaneous events:
  - A flush together with a valid in_packet: the flush wins.
  - Two in-flight entries with the same rt: both write back in order, and forwarding follows the youngest.
- Latency 0 or unit id 0 is illegal. Such a packet is dropped and never forwarded.

## Timing
- Reset (reset=0, asynchronous):
  - Every stage valid is 0.
  - wb_wrt_en=0, wb_rt_address=0, wb_data=0.
  - fwd_hit=0, fwd_pending=0, fwd_ra/rb/rc=0.
- A packet accepted at edge N sits in stage 1 after N and reaches stage 7 after N+6. wb_wrt_en is high for exactly the cycle after edge N+7.
- Forwarding outputs reflect register state in the same cycle, with zero added latency.
- Reset asserted mid-operation drops all in-flight entries. No partial writeback occurs, and wb_wrt_en falls asynchronously.

## Configuration
- ODD_RESULT_FWD_EN defined: the forwarding lookup is built as described.
- Not defined: fwd_hit, fwd_pending and fwd_ra/rb/rc are tied to 0 and the lookup logic is omitted. Staging and writeback are unchanged.

## Structure
- Shared package `descriptions` gains:
  - a `odd_packet_t` struct matching the 143-bit layout;
  - constants ODD_PKT_W=143 and ODD_STAGES=7.
- One sub-module, `odd_fwd_lookup`, is instantiated three times (ra, rb, rc). It takes the stage array plus one address and returns hit, pending and data.

## Test plan
- Single packet: rt=5, result=128'hA5, latency=2, wen=1.
  - rb_address=5 gives pending at stage 1 and hit with data A5 from stage 2 onward.
  - wb_wrt_en pulses 7 cycles after acceptance with wb_rt_address=5.
- Same-rt hazard: rt=9, latency=4, data=1, followed next cycle by rt=9, latency=7, data=2.
  - ra_address=9 reports pending (younger entry) even though the older entry is ready.
  - Writebacks occur in order: 1, then 2.
- Flush:
  - Packet A (rt=3) accepted, then in_flush asserted while packet B (rt=4) is presented.
  - Neither A nor B ever writes back, and there is no hit for 3 or 4.
- Reset mid-stream:
  - Seven back-to-back packets, then reset pulsed low while they are in flight.
  - All outputs are 0 immediately, with no writeback after release.
- Illegal and disabled packets: wen=0 or latency=0 with rt=12 gives no hit, no pending and no writeback.
- Build without ODD_RESULT_FWD_EN: the single-packet scenario gives fwd_* = 0 throughout, with identical writeback.
